// File: rtl/instr_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues level-style requests to instruction memory and captures returned
// words into IF/ID. Taken CBZ branches flush IF/ID and redirect the PC. A
// request still in flight when a branch is taken is drained and its data
// dropped. The optional macro FETCH_PREFETCH_EN adds a one-entry skid buffer.
// That buffer absorbs a word that returns while decode is stalled.
module instr_fetch #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic [PC_W-1:0] br_pc,
  input  logic [18:0]     br_offset,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [10:0]     id_opcode,
  output logic [PC_W-1:0] id_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // pc is the address being requested; it stays on the old address during
  // DRAIN, while tgt holds the redirect taken once the stale ack arrives.
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W-1:0] tgt, tgt_nxt;

  logic            id_valid_nxt;
  logic [31:0]     id_instr_nxt;
  logic [PC_W-1:0] id_pc_nxt;

`ifdef FETCH_PREFETCH_EN
  logic            skid_vld_p0, skid_vld_nxt;
  logic [31:0]     skid_instr_p0, skid_instr_nxt;
  logic [PC_W-1:0] skid_pc_p0, skid_pc_nxt;
`endif

  logic            taken;
  logic            slot_free;
  logic            req_gate;
  logic            accept;
  logic [PC_W-1:0] br_target;

  // Branch target: word offset sign-extended, scaled to bytes, wraps at PC_W.
  function automatic logic [PC_W-1:0] branch_target(
    input logic [PC_W-1:0]   base,
    input logic signed [18:0] off
  );
    logic signed [PC_W-1:0] ext;
    ext = {{(PC_W-19){off[18]}}, off};
    return base + PC_W'(ext <<< 2);
  endfunction

  assign taken     = branch & zero;
  assign br_target = branch_target(br_pc, signed'(br_offset));
  assign slot_free = !id_valid || !stall;

`ifdef FETCH_PREFETCH_EN
  assign req_gate = !skid_vld_p0;
`else
  assign req_gate = slot_free;
`endif

  assign imem_req  = (state == DRAIN) || ((state == FETCH) && req_gate);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack;
  assign id_opcode = id_instr[31:21];

  // Next-state, PC, IF/ID and skid-buffer updates.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    tgt_nxt      = tgt;
    id_valid_nxt = id_valid;
    id_instr_nxt = id_instr;
    id_pc_nxt    = id_pc;
`ifdef FETCH_PREFETCH_EN
    skid_vld_nxt   = skid_vld_p0;
    skid_instr_nxt = skid_instr_p0;
    skid_pc_nxt    = skid_pc_p0;
`endif
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (taken) begin
          // Flush wins over stall and over any word returning this cycle.
          id_valid_nxt = 1'b0;
          id_instr_nxt = '0;
`ifdef FETCH_PREFETCH_EN
          skid_vld_nxt = 1'b0;
`endif
          if (imem_req && !imem_ack) begin
            state_nxt = DRAIN;
            tgt_nxt   = br_target;
          end else begin
            pc_nxt = br_target;
          end
        end else begin
`ifdef FETCH_PREFETCH_EN
          if (slot_free) begin
            if (skid_vld_p0) begin
              id_valid_nxt = 1'b1;
              id_instr_nxt = skid_instr_p0;
              id_pc_nxt    = skid_pc_p0;
              skid_vld_nxt = 1'b0;
            end else if (accept) begin
              id_valid_nxt = 1'b1;
              id_instr_nxt = imem_rdata;
              id_pc_nxt    = pc;
            end else begin
              id_valid_nxt = 1'b0;
              id_instr_nxt = '0;
            end
          end else if (accept) begin
            skid_vld_nxt   = 1'b1;
            skid_instr_nxt = imem_rdata;
            skid_pc_nxt    = pc;
          end
`else
          if (accept) begin
            id_valid_nxt = 1'b1;
            id_instr_nxt = imem_rdata;
            id_pc_nxt    = pc;
          end else if (!stall) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = '0;
          end
`endif
          if (accept) begin
            pc_nxt = pc + PC_W'(4);
          end
        end
      end
      DRAIN: begin
        id_valid_nxt = 1'b0;
        id_instr_nxt = '0;
        if (taken) begin
          tgt_nxt = br_target;
        end
        if (imem_ack) begin
          state_nxt = FETCH;
          pc_nxt    = taken ? br_target : tgt;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and pipeline registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      tgt      <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
`ifdef FETCH_PREFETCH_EN
      skid_vld_p0   <= 1'b0;
      skid_instr_p0 <= '0;
      skid_pc_p0    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      tgt      <= tgt_nxt;
      id_valid <= id_valid_nxt;
      id_instr <= id_instr_nxt;
      id_pc    <= id_pc_nxt;
`ifdef FETCH_PREFETCH_EN
      skid_vld_p0   <= skid_vld_nxt;
      skid_instr_p0 <= skid_instr_nxt;
      skid_pc_p0    <= skid_pc_nxt;
`endif
    end
  end

endmodule
